// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational instruction ROM between the
// instruction-fetch (IF) and data-load (DL) ports. Each access is two cycles.
// In IDLE a winner is picked and its address is latched. In ACCESS the ROM is
// driven and the word is registered. On the following cycle a one-cycle rvalid
// pulse is returned to the owner.
//
// Handshake: a requester raises *_req with a stable *_addr and holds both
// until it sees *_gnt high. The request is consumed in the gnt cycle, and the
// requester may drop or change req/addr after the edge that ends it. The
// response arrives as a one-cycle *_rvalid pulse on the cycle after gnt.
// *_rdata and *_err then hold until that port's next response. There is no
// back-pressure on the response side.
module rom_port_arbiter #(
  parameter logic [15:0] ROM_BASE     = 16'h8000,
  parameter logic [15:0] ROM_DEPTH    = 16'h1000,
  parameter int          STARVE_LIMIT = 4,
  parameter int          CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dl_req,
  input  logic [15:0] dl_addr,
  output logic        dl_gnt,
  output logic        dl_rvalid,
  output logic [31:0] dl_rdata,
  output logic        dl_err,
  output logic [15:0] rom_addr,
  output logic        rom_oe,
  input  logic [31:0] rom_data
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DL = 1'b1;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [0:0]       state;
  logic             owner;
  logic [15:0]      addr_q;
  logic [CNT_W-1:0] starve_cnt;

  logic             dl_wins;
  logic [15:0]      offset;
  logic             in_win;
  logic [31:0]      read_word;

  // DL wins when IF is idle, or when DL has been passed over too often.
  assign dl_wins = dl_req && (!if_req || (starve_cnt >= STARVE_MAX));

  // Window check on the latched address. The offset is an unsigned 16-bit
  // subtraction, which only means anything once addr_q >= ROM_BASE.
  assign offset    = addr_q - ROM_BASE;
  assign in_win    = (addr_q >= ROM_BASE) && (offset < ROM_DEPTH);
  assign read_word = in_win ? rom_data : 32'h0;

  // ROM drive and grants exist only in ACCESS. oe stays low otherwise so the
  // ROM bus floats.
  assign rom_oe   = (state == ACCESS) && in_win;
  assign rom_addr = (state == ACCESS) ? addr_q : 16'h0;
  assign if_gnt   = (state == ACCESS) && (owner == OWN_IF);
  assign dl_gnt   = (state == ACCESS) && (owner == OWN_DL);

  // Arbitration FSM, starvation counter and per-port response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      addr_q     <= 16'h0;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      if_err     <= 1'b0;
      dl_rvalid  <= 1'b0;
      dl_rdata   <= 32'h0;
      dl_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dl_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_wins) begin
            owner      <= OWN_DL;
            addr_q     <= dl_addr;
            state      <= ACCESS;
            starve_cnt <= '0;
          end else if (if_req) begin
            owner  <= OWN_IF;
            addr_q <= if_addr;
            state  <= ACCESS;
            if (!dl_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt < STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (owner == OWN_DL) begin
            dl_rdata  <= read_word;
            dl_err    <= !in_win;
            dl_rvalid <= 1'b1;
          end else begin
            if_rdata  <= read_word;
            if_err    <= !in_win;
            if_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
